wtm_pipe: RTL and testbench
===========================

Name: wtm_pipe

Overview:
- Parametrised, 3-stage pipelined Wallace-tree multiplier. Successor to the 5x5 combinational Wallace-tree block.
- Adds an operand width parameter, a signed/unsigned mode per transaction, a truncation-overflow flag, and valid/ready handshakes on input and output.
- Sits between operand-producing datapath logic and a result consumer that can stall.

Parameters:
WIDTH, 5, operand width in bits; legal range 2..16; product width is 2*WIDTH

Ports:
clock  input  1  single system clock, rising edge
reset_n  input  1  asynchronous active-low reset; deassertion is synchronised externally
in_valid  input  1  operand pair present
in_ready  output  1  block accepts operands this cycle
in1  input  WIDTH  multiplicand
in2  input  WIDTH  multiplier
signed_mode  input  1  1 = two's-complement operands, 0 = unsigned
out_valid  output  1  result present
out_ready  input  1  consumer accepts result this cycle
out  output  2*WIDTH  product
ovf  output  1  product does not fit in WIDTH bits of the selected signedness

Behaviour:
- Reset (reset_n=0, asynchronous):
  - All stage valid bits clear; out_valid=0, out=0, ovf=0.
  - in_ready=1 once reset_n=1.
  - Reset mid-operation discards every in-flight transaction. No result is emitted for it.
- Handshake and stall:
  - Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
  - stall = out_valid && !out_ready. in_ready = !stall (combinational).
  - While stall=1, all pipeline registers hold. out, ovf and out_valid stay stable until accepted.
  - Bubbles are not collapsed. Empty stages still advance when stall=0.
- Pipeline, latency 3 cycles from input transfer to out_valid with no stall; throughput 1 per cycle:
  - S1: register in1, in2, signed_mode. Generate the WIDTH x WIDTH AND partial-product matrix. In signed mode apply Baugh-Wooley: invert the MSB-row/column cross terms, add constant 1 at bit WIDTH and bit 2*WIDTH-1. Register the matrix.
  - S2: Wallace reduction with rows of 3:2 counters (and half adders) until two rows of 2*WIDTH bits remain. Register them.
  - S3: ripple or prefix CPA of the two rows, truncated to 2*WIDTH bits. Compute ovf. Register out, ovf, out_valid.
- Arithmetic:
  - Unsigned: out = in1*in2, exact in 2*WIDTH bits.
  - Signed: out = two's-complement product in 2*WIDTH bits. The -2^(WIDTH-1) * -2^(WIDTH-1) case is exact, positive, and fits.
  - The CPA carry out of bit 2*WIDTH-1 is discarded (Baugh-Wooley wrap).
- ovf:
  - Unsigned: ovf = |out[2*WIDTH-1:WIDTH].
  - Signed: ovf = 1 unless out[2*WIDTH-1:WIDTH-1] is all zeros or all ones.
- signed_mode travels with its operands through every stage. Mixed-mode back-to-back transactions are legal.
- Simultaneous input and output transfer in the same cycle is legal and required for full throughput.

Decomposition:
- Shared header wtm_defs.vh holds:
  - WTM_LATENCY = 3
  - Legal WIDTH bounds (2, 16)
  - A width-check macro that fires a simulation error for an out-of-range WIDTH
- One sub-module, wtm_csa_row: a parametrised row of full adders (3 vectors -> sum and carry vectors, carry shifted left 1). It is instantiated in a generate loop forming the S2 tree.
- Partial-product generation and the CPA stay inline.

Test Plan (WIDTH=5 unless stated):
- Unsigned, out_ready=1: (0,20) then (25,16) then (31,1), one per cycle -> out_valid on cycles 3, 4, 5 with out=0/ovf=0, out=400/ovf=1, out=31/ovf=0.
- Signed: (5'b11111, 5'b00001) -> out=10'h3FF (-1), ovf=0. Then (5'b10000, 5'b10000) -> out=256, ovf=1. Then (5'b10000, 5'b00001) -> out=10'h3F0 (-16), ovf=0.
- Backpressure:
  - Stimulus: stream 5 products, hold out_ready=0 from cycle 3 for 4 cycles, then release.
  - Required: in_ready=0 exactly while out_valid=1 and out_ready=0, and out holds its first result.
  - Required after release: all 5 results appear in order, no loss or duplication.
- Reset mid-flight: assert reset_n=0 asynchronously, between clock edges, with 2 transactions in flight -> out_valid=0 and out=0 immediately. No stale result after release; the next input yields the correct product 3 cycles later.
- Exhaustive: WIDTH=4 and WIDTH=8, all operand pairs in both modes, random in_valid/out_ready -> every out/ovf matches the reference model and ordering is preserved.

Source files
------------

// File: rtl/wtm_pipe_pkg.sv
// wtm_pipe_pkg: shared constants and elaboration-time helpers for the
// pipelined Wallace-tree multiplier.
//   WTM_LATENCY          cycles from input transfer to out_valid (no stall)
//   WTM_WIDTH_MIN/MAX    legal operand widths
//   wtm_rows_after()     row count after one level of 3:2 compression
//   wtm_rows_at()        row count entering a given tree level
//   wtm_tree_levels()    number of levels needed to reach two rows
package wtm_pipe_pkg;

  localparam int WTM_LATENCY   = 3;
  localparam int WTM_WIDTH_MIN = 2;
  localparam int WTM_WIDTH_MAX = 16;

  // Every complete group of three rows becomes two; leftovers pass through.
  function automatic int wtm_rows_after(input int n);
    return 2 * (n / 3) + (n % 3);
  endfunction

  function automatic int wtm_rows_at(input int r0, input int lvl);
    int n;
    n = r0;
    for (int i = 0; i < lvl; i++) n = wtm_rows_after(n);
    return n;
  endfunction

  function automatic int wtm_tree_levels(input int r0);
    int n;
    int c;
    n = r0;
    c = 0;
    while (n > 2) begin
      n = wtm_rows_after(n);
      c++;
    end
    return c;
  endfunction

endpackage

// File: rtl/wtm_csa_row.sv
// wtm_csa_row: one row of full adders (3:2 counters) across W bit columns.
//   a, b, c  three addend vectors of the same weight
//   sum      bitwise sum
//   carry    majority bits shifted left by one; the carry out of the MSB
//            is dropped because the product is taken modulo 2^W
module wtm_csa_row #(
  parameter int W = 10
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);

  always_comb begin
    sum   = a ^ b ^ c;
    carry = '0;
    for (int k = 1; k < W; k++) begin
      carry[k] = (a[k-1] & b[k-1]) | (a[k-1] & c[k-1]) | (b[k-1] & c[k-1]);
    end
  end

endmodule

// File: rtl/wtm_pipe.sv
// wtm_pipe: 3-stage pipelined Wallace-tree multiplier, unsigned or
// two's-complement per transaction.
//   clock, reset_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready       operand handshake (in1, in2, signed_mode)
//   out_valid/out_ready     result handshake (out, ovf)
//   out                     2*WIDTH-bit product
//   ovf                     product does not fit in WIDTH bits of the
//                           selected signedness
// Stages: S1 registers the partial-product matrix, S2 registers the two
// rows left by the CSA tree, S3 registers the carry-propagate sum.
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// The only stall source is a presented result that is not taken
// (out_valid && !out_ready); then every stage holds and in_ready drops
// in the same cycle. Otherwise all stages, bubbles included, advance.
module wtm_pipe
  import wtm_pipe_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out,
  output logic               ovf
);

  localparam int P    = 2 * WIDTH;
  // WIDTH partial-product rows plus one row for the Baugh-Wooley constants.
  localparam int R0   = WIDTH + 1;
  localparam int NLVL = wtm_tree_levels(R0);

  if (WIDTH < WTM_WIDTH_MIN || WIDTH > WTM_WIDTH_MAX) begin : g_width_check
    $error("wtm_pipe: WIDTH %0d outside legal range %0d..%0d",
           WIDTH, WTM_WIDTH_MIN, WTM_WIDTH_MAX);
  end

  logic         stall;
  logic         v1_q, v1_d, v2_q, v2_d, ovalid_q, ovalid_d;
  logic         sgn1_q, sgn1_d, sgn2_q, sgn2_d;
  logic [P-1:0] pp_q [R0];
  logic [P-1:0] pp_d [R0];
  logic [P-1:0] rows_q [2];
  logic [P-1:0] rows_d [2];
  logic [P-1:0] out_q, out_d;
  logic         ovf_q, ovf_d;
  logic [P-1:0] lvl [NLVL+1][R0];
  logic [P-1:0] sum;
  logic [WIDTH:0] hi;
  logic         bit_v;

  // Stage control: valid and signedness travel with their data.
  always_comb begin
    stall    = ovalid_q && !out_ready;
    in_ready = !stall;
    v1_d     = in_valid;
    sgn1_d   = signed_mode;
    v2_d     = v1_q;
    sgn2_d   = sgn1_q;
    ovalid_d = v2_q;
  end

  // S1: partial-product matrix. In signed mode the cross terms involving
  // exactly one sign bit are inverted and 1s are added at bits WIDTH and
  // 2*WIDTH-1 (modified Baugh-Wooley); the sum then wraps mod 2^(2*WIDTH).
  always_comb begin
    bit_v = 1'b0;
    for (int i = 0; i < R0; i++) pp_d[i] = '0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        bit_v = in1[j] & in2[i];
        if (signed_mode && ((i == WIDTH - 1) != (j == WIDTH - 1))) bit_v = ~bit_v;
        pp_d[i][i+j] = bit_v;
      end
    end
    if (signed_mode) begin
      pp_d[WIDTH][WIDTH] = 1'b1;
      pp_d[WIDTH][P-1]   = 1'b1;
    end
  end

  // S2: Wallace tree. Each level compresses groups of three rows into two;
  // rows beyond the live count of a level are tied to zero.
  for (genvar j = 0; j < R0; j++) begin : g_lvl0
    assign lvl[0][j] = pp_q[j];
  end

  for (genvar l = 0; l < NLVL; l++) begin : g_lvl
    localparam int N  = wtm_rows_at(R0, l);
    localparam int G  = N / 3;
    localparam int NN = wtm_rows_after(N);
    for (genvar g = 0; g < G; g++) begin : g_csa
      wtm_csa_row #(.W(P)) u_csa (
        .a     (lvl[l][3*g]),
        .b     (lvl[l][3*g+1]),
        .c     (lvl[l][3*g+2]),
        .sum   (lvl[l+1][2*g]),
        .carry (lvl[l+1][2*g+1])
      );
    end
    for (genvar k = 0; k < N % 3; k++) begin : g_pass
      assign lvl[l+1][2*G+k] = lvl[l][3*G+k];
    end
    for (genvar k = NN; k < R0; k++) begin : g_zero
      assign lvl[l+1][k] = '0;
    end
  end

  always_comb begin
    rows_d[0] = lvl[NLVL][0];
    rows_d[1] = lvl[NLVL][1];
  end

  // S3: carry-propagate add; the carry out of the top bit is discarded.
  // The output register is only reloaded by a valid stage, so the last
  // result stays visible across bubbles.
  always_comb begin
    sum   = rows_q[0] + rows_q[1];
    hi    = sum[P-1:WIDTH-1];
    out_d = out_q;
    ovf_d = ovf_q;
    if (v2_q) begin
      out_d = sum;
      if (sgn2_q) ovf_d = !((hi == '0) || (hi == '1));
      else        ovf_d = |sum[P-1:WIDTH];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      ovalid_q  <= 1'b0;
      sgn1_q    <= 1'b0;
      sgn2_q    <= 1'b0;
      for (int i = 0; i < R0; i++) pp_q[i] <= '0;
      rows_q[0] <= '0;
      rows_q[1] <= '0;
      out_q     <= '0;
      ovf_q     <= 1'b0;
    end else if (!stall) begin
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      ovalid_q  <= ovalid_d;
      sgn1_q    <= sgn1_d;
      sgn2_q    <= sgn2_d;
      for (int i = 0; i < R0; i++) pp_q[i] <= pp_d[i];
      rows_q[0] <= rows_d[0];
      rows_q[1] <= rows_d[1];
      out_q     <= out_d;
      ovf_q     <= ovf_d;
    end
  end

  assign out_valid = ovalid_q;
  assign out       = out_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_wtm_pipe.sv
// tb_wtm_pipe: bench for wtm_pipe. Three instances (WIDTH 4, 5, 8) share the
// operand and handshake drivers; sel picks which one is driven and observed.
module tb_wtm_pipe;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        signed_mode = 1'b0;
  logic [15:0] a_drv = '0;
  logic [15:0] b_drv = '0;
  int          sel = 5;

  logic        iv4, iv5, iv8, ir4, ir5, ir8, ov4, ov5, ov8, of4, of5, of8;
  logic [7:0]  o4;
  logic [9:0]  o5;
  logic [15:0] o8;

  logic        cur_in_ready, cur_ovalid, cur_ovf;
  logic [31:0] cur_out;

  int          checks = 0;
  int          fails = 0;
  logic [32:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, fails=%0d", fails);
    $fatal(1, "watchdog");
  end

  assign iv4 = in_valid && (sel == 4);
  assign iv5 = in_valid && (sel == 5);
  assign iv8 = in_valid && (sel == 8);

  always_comb begin
    cur_in_ready = ir5;
    cur_ovalid   = ov5;
    cur_ovf      = of5;
    cur_out      = {22'b0, o5};
    if (sel == 4) begin
      cur_in_ready = ir4; cur_ovalid = ov4; cur_ovf = of4; cur_out = {24'b0, o4};
    end else if (sel == 8) begin
      cur_in_ready = ir8; cur_ovalid = ov8; cur_ovf = of8; cur_out = {16'b0, o8};
    end
  end

  wtm_pipe #(.WIDTH(4)) u_dut4 (
    .clock(clock), .reset_n(reset_n), .in_valid(iv4), .in_ready(ir4),
    .in1(a_drv[3:0]), .in2(b_drv[3:0]), .signed_mode(signed_mode),
    .out_valid(ov4), .out_ready(out_ready), .out(o4), .ovf(of4));

  wtm_pipe #(.WIDTH(5)) u_dut5 (
    .clock(clock), .reset_n(reset_n), .in_valid(iv5), .in_ready(ir5),
    .in1(a_drv[4:0]), .in2(b_drv[4:0]), .signed_mode(signed_mode),
    .out_valid(ov5), .out_ready(out_ready), .out(o5), .ovf(of5));

  wtm_pipe #(.WIDTH(8)) u_dut8 (
    .clock(clock), .reset_n(reset_n), .in_valid(iv8), .in_ready(ir8),
    .in1(a_drv[7:0]), .in2(b_drv[7:0]), .signed_mode(signed_mode),
    .out_valid(ov8), .out_ready(out_ready), .out(o8), .ovf(of8));

  // ---------------- reference model ----------------
  // Integer product of the operands as numbers, reduced mod 2^(2w); overflow
  // means the product lies outside the w-bit range of the chosen signedness.
  function automatic logic [32:0] ref_model(input int w, input logic [15:0] a,
                                            input logic [15:0] b, input logic s);
    longint ai, bi, prod, full, half;
    logic [31:0] p;
    logic o;
    full = longint'(1) << w;
    half = full >> 1;
    ai = longint'(a) % full;
    bi = longint'(b) % full;
    if (s && ai >= half) ai = ai - full;
    if (s && bi >= half) bi = bi - full;
    prod = ai * bi;
    p = 32'(prod & ((longint'(1) << (2 * w)) - 1));
    if (s) o = (prod < -half) || (prod >= half);
    else   o = (prod >= full);
    return {o, p};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sel = 5;
    repeat (3) @(negedge clock);
    checks++;
    if (cur_ovalid !== 1'b0 || cur_out !== 32'd0 || cur_ovf !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: out_valid=%b out=%h ovf=%b, required 0/0/0", cur_ovalid, cur_out, cur_ovf);
    end
    reset_n = 1'b1;
    @(negedge clock); #1;
    checks++;
    if (cur_in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_ready: in_ready=%b, required 1", cur_in_ready);
    end
  endtask

  // Three back-to-back transfers; results on the 3rd, 4th and 5th cycle.
  task automatic test_directed(input logic s, input logic [15:0] a0, input logic [15:0] b0,
                               input logic [9:0] p0, input logic f0,
                               input logic [15:0] a1, input logic [15:0] b1,
                               input logic [9:0] p1, input logic f1,
                               input logic [15:0] a2, input logic [15:0] b2,
                               input logic [9:0] p2, input logic f2);
    logic [15:0] av [3];
    logic [15:0] bv [3];
    logic [9:0]  pv [3];
    logic        fv [3];
    av[0] = a0; av[1] = a1; av[2] = a2;
    bv[0] = b0; bv[1] = b1; bv[2] = b2;
    pv[0] = p0; pv[1] = p1; pv[2] = p2;
    fv[0] = f0; fv[1] = f1; fv[2] = f2;
    sel = 5; out_ready = 1'b1; signed_mode = s;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      if (k < 3) begin
        in_valid = 1'b1; a_drv = av[k]; b_drv = bv[k];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (k == 2) begin
        checks++;
        if (cur_ovalid !== 1'b0) begin
          fails++;
          $display("FAIL directed_latency mode=%b: out_valid=%b after 2 cycles, required 0", s, cur_ovalid);
        end
      end
      if (k >= 3) begin
        checks++;
        if (cur_ovalid !== 1'b1 || cur_out[9:0] !== pv[k-3] || cur_ovf !== fv[k-3]) begin
          fails++;
          $display("FAIL directed mode=%b txn%0d: valid=%b out=%h ovf=%b, required 1 %h %b",
                   s, k - 3, cur_ovalid, cur_out[9:0], cur_ovf, pv[k-3], fv[k-3]);
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_unsigned();
    test_directed(1'b0, 16'd0, 16'd20, 10'd0, 1'b0,
                        16'd25, 16'd16, 10'd400, 1'b1,
                        16'd31, 16'd1, 10'd31, 1'b0);
  endtask

  task automatic test_signed();
    test_directed(1'b1, 16'h1F, 16'h01, 10'h3FF, 1'b0,
                        16'h10, 16'h10, 10'd256, 1'b1,
                        16'h10, 16'h01, 10'h3F0, 1'b0);
  endtask

  task automatic test_backpressure();
    logic [15:0] av [5];
    logic [15:0] bv [5];
    logic        sv [5];
    logic [32:0] ev [5];
    int sent, got, k;
    for (int i = 0; i < 5; i++) begin
      av[i] = 16'($urandom_range(0, 31));
      bv[i] = 16'($urandom_range(0, 31));
      sv[i] = 1'($urandom_range(0, 1));
      ev[i] = ref_model(5, av[i], bv[i], sv[i]);
    end
    sel = 5; sent = 0; got = 0; k = 0;
    while (got < 5 && k < 40) begin
      @(negedge clock);
      out_ready = !(k >= 3 && k < 7);
      if (sent < 5) begin
        in_valid = 1'b1; a_drv = av[sent]; b_drv = bv[sent]; signed_mode = sv[sent];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      checks++;
      if (cur_in_ready !== !(cur_ovalid && !out_ready)) begin
        fails++;
        $display("FAIL bp_in_ready cycle %0d: in_ready=%b out_valid=%b out_ready=%b", k, cur_in_ready, cur_ovalid, out_ready);
      end
      if (k >= 3 && k < 7) begin
        checks++;
        if (cur_ovalid !== 1'b1 || {cur_ovf, cur_out} !== ev[0]) begin
          fails++;
          $display("FAIL bp_hold cycle %0d: valid=%b ovf/out=%h, required 1 %h", k, cur_ovalid, {cur_ovf, cur_out}, ev[0]);
        end
      end
      if (cur_ovalid && out_ready) begin
        checks++;
        if (got >= 5) begin
          fails++;
          $display("FAIL bp_order: extra result %h", {cur_ovf, cur_out});
        end else if ({cur_ovf, cur_out} !== ev[got]) begin
          fails++;
          $display("FAIL bp_order result %0d: ovf/out=%h, required %h", got, {cur_ovf, cur_out}, ev[got]);
        end
        got++;
      end
      if (in_valid && cur_in_ready) sent++;
      k++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (got != 5) begin
      fails++;
      $display("FAIL bp_count: received %0d results, required 5", got);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clock); #1;
      checks++;
      if (cur_ovalid !== 1'b0) begin
        fails++;
        $display("FAIL bp_duplicate: out_valid=%b out=%h after drain, required 0", cur_ovalid, cur_out);
      end
    end
  endtask

  task automatic test_reset_midflight();
    sel = 5; signed_mode = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      in_valid = 1'b1;
      a_drv = 16'(3 + 9 * k);
      b_drv = 16'(7 + k);
    end
    @(negedge clock);
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    checks++;
    if (cur_ovalid !== 1'b1 || cur_out[9:0] !== 10'd21) begin
      fails++;
      $display("FAIL rst_pre: valid=%b out=%h, required 1 015", cur_ovalid, cur_out[9:0]);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (cur_ovalid !== 1'b0 || cur_out !== 32'd0 || cur_ovf !== 1'b0) begin
      fails++;
      $display("FAIL rst_async: valid=%b out=%h ovf=%b, required 0/0/0", cur_ovalid, cur_out, cur_ovf);
    end
    @(negedge clock);
    #2 reset_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock); #1;
      checks++;
      if (cur_ovalid !== 1'b0) begin
        fails++;
        $display("FAIL rst_stale cycle %0d: out_valid=%b out=%h, required 0", k, cur_ovalid, cur_out);
      end
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      in_valid = (k == 0);
      a_drv = 16'd13; b_drv = 16'd11;
      #1;
      checks++;
      if (k < 3 && cur_ovalid !== 1'b0) begin
        fails++;
        $display("FAIL rst_next_early cycle %0d: out_valid=%b, required 0", k, cur_ovalid);
      end else if (k == 3 && (cur_ovalid !== 1'b1 || cur_out[9:0] !== 10'd143 || cur_ovf !== 1'b1)) begin
        fails++;
        $display("FAIL rst_next: valid=%b out=%h ovf=%b, required 1 08f 1", cur_ovalid, cur_out[9:0], cur_ovf);
      end
    end
    in_valid = 1'b0;
  endtask

  // Random in_valid/out_ready stream against the scoreboard. With
  // exhaustive=1 the operand pairs and modes are enumerated in order.
  task automatic test_stream(input int w, input int n_txn, input bit exhaustive);
    int sent, cyc, limit;
    bit pending, prev_stall;
    logic [32:0] prev_obs, e;
    logic [15:0] mask;
    sel = w; exp_q.delete(); sent = 0; cyc = 0; pending = 0; prev_stall = 0;
    prev_obs = '0; limit = 20 * n_txn + 100;
    mask = 16'((32'd1 << w) - 1);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(negedge clock);
    while ((sent < n_txn || exp_q.size() != 0) && cyc < limit) begin
      @(negedge clock);
      cyc++;
      if (!pending && sent < n_txn && $urandom_range(0, 99) < 75) begin
        pending = 1;
        if (exhaustive) begin
          a_drv = 16'(sent) & mask;
          b_drv = 16'(sent >> w) & mask;
          signed_mode = 1'((sent >> (2 * w)) & 1);
        end else begin
          a_drv = 16'($urandom) & mask;
          b_drv = 16'($urandom) & mask;
          signed_mode = 1'($urandom_range(0, 1));
        end
      end else if (!pending) begin
        a_drv = 16'($urandom);
        b_drv = 16'($urandom);
        signed_mode = 1'($urandom_range(0, 1));
      end
      in_valid = pending;
      out_ready = ($urandom_range(0, 99) < 65);
      #1;
      checks++;
      if (cur_in_ready !== !(cur_ovalid && !out_ready)) begin
        fails++;
        $display("FAIL stream_w%0d_in_ready: in_ready=%b out_valid=%b out_ready=%b", w, cur_in_ready, cur_ovalid, out_ready);
      end
      if (prev_stall) begin
        checks++;
        if (cur_ovalid !== 1'b1 || {cur_ovf, cur_out} !== prev_obs) begin
          fails++;
          $display("FAIL stream_w%0d_hold: valid=%b ovf/out=%h, required 1 %h", w, cur_ovalid, {cur_ovf, cur_out}, prev_obs);
        end
      end
      prev_stall = cur_ovalid && !out_ready;
      prev_obs = {cur_ovf, cur_out};
      if (cur_ovalid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL stream_w%0d_unexpected: ovf/out=%h with empty scoreboard", w, {cur_ovf, cur_out});
        end else begin
          e = exp_q.pop_front();
          if ({cur_ovf, cur_out} !== e) begin
            fails++;
            $display("FAIL stream_w%0d_result: ovf/out=%h, required %h", w, {cur_ovf, cur_out}, e);
          end
        end
      end
      if (pending && cur_in_ready) begin
        exp_q.push_back(ref_model(w, a_drv, b_drv, signed_mode));
        sent++;
        pending = 0;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (sent != n_txn || exp_q.size() != 0) begin
      fails++;
      $display("FAIL stream_w%0d_done: sent %0d of %0d, %0d results outstanding after %0d cycles",
               w, sent, n_txn, exp_q.size(), cyc);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_backpressure();
    test_reset_midflight();
    test_stream(4, 512, 1'b1);
    test_stream(8, 1500, 1'b0);
    test_stream(5, 400, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
